sa_feeder: RTL and testbench
============================

Name: sa_feeder

Overview:
- Transmit-side driver for one systolic PE array of ROWS x COLS PEs.
- Sequences the weight-preload phase: drives `mode` and the per-column `weight` tops, bottom-row weights first.
- Then streams activation vectors into the row inputs `a`, skewed by row and padded with zeros.
- Sits between the layer controller / activation buffer and the array boundary. It is the source for every `a`, `weight` and `mode` the PEs receive.

Parameters:
- ROWS, 4, number of PE rows (activation lanes).
- COLS, 4, number of PE columns (weight lanes).
- PORT_WIDTH, 8, signed activation/weight width.
- ROW_SKEW, 4, extra cycles of delay per row index. Row r output is delayed r*ROW_SKEW cycles; default matches the PE partial-sum path.
- DRAIN_CYCLES, 32, zero-feed cycles after the last vector so in-flight sums exit the array.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse; begins a job when idle.
- load_w, in, 1, sampled with start; 1 = run a weight preload before feeding.
- busy, out, 1, high from accepted start until done.
- done, out, 1, one-cycle pulse at end of drain.
- w_valid, in, 1, weight beat valid.
- w_ready, out, 1, weight beat accepted.
- w_data, in, COLS*PORT_WIDTH, one PE row of weights; column c occupies bits [c*PORT_WIDTH +: PORT_WIDTH].
- act_valid, in, 1, activation vector valid.
- act_ready, out, 1, activation vector accepted.
- act_data, in, ROWS*PORT_WIDTH, one vector; row r occupies bits [r*PORT_WIDTH +: PORT_WIDTH].
- act_last, in, 1, marks the final vector of the job.
- mode, out, 1, array mode (1 = weight shift, 0 = inference).
- weight_col, out, COLS*PORT_WIDTH, to the weight input of each top-row PE.
- a_row, out, ROWS*PORT_WIDTH, to the `a` input of each left-column PE, already skewed.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all skew registers cleared. Outputs: busy=0, done=0, w_ready=0, act_ready=0, mode=0, weight_col=0, a_row=0.
- All outputs are registered.
- FSM states: IDLE, LOAD_W, FEED, DRAIN.
- IDLE:
  - On start with load_w=1 -> LOAD_W, beat counter cleared.
  - On start with load_w=0 -> FEED.
  - busy rises the cycle after start.
- LOAD_W:
  - w_ready=1. Each w_valid&w_ready beat registers weight_col<=w_data and mode<=1 for exactly that next cycle.
  - Stall cycles (w_valid=0): mode=0, weight_col held, a_row=0.
  - Beats are presented bottom-row first. After ROWS beats -> FEED; mode returns to 0 the cycle after the last beat's mode cycle.
  - Exactly ROWS cycles of mode=1 per job.
- FEED:
  - act_ready=1. Accepted vector enters the skew stage; unskewed row 0 appears on a_row the next cycle.
  - Row r is delayed a further r*ROW_SKEW cycles via a per-row shift chain of depth r*ROW_SKEW.
  - Bubble cycles (act_valid=0) inject a zero vector into the skew chains. Zero activations contribute nothing to sums.
  - Accepting a vector with act_last=1 -> DRAIN, drain counter cleared.
- DRAIN:
  - act_ready=0; zeros injected each cycle for DRAIN_CYCLES cycles.
  - Then done pulses for 1 cycle, busy falls the same cycle, -> IDLE.
- start while busy: ignored.
- w_valid outside LOAD_W and act_valid outside FEED: not accepted (ready=0).
- act_last on the very first vector is legal: one vector, then drain.
- Reset mid-job: everything clears immediately, including skew chains. mode is guaranteed 0 after reset, so the array never sees a partial weight shift continued.
- Counters: beat counter sized clog2(ROWS+1); drain counter sized clog2(DRAIN_CYCLES+1). No wrap within a job.

Decomposition:
- Shared package: FSM state encoding, and the localparams SKEW_DEPTH(r)=r*ROW_SKEW and beat/drain counter widths.
- One natural sub-module: sa_skew_line (parameters DEPTH and PORT_WIDTH; zero-reset shift register). Instantiated per row r>0 with DEPTH=r*ROW_SKEW; row 0 uses depth 0 (pass-through).

Test Plan:
- Preload, ROWS=4: start+load_w=1, 4 back-to-back beats with w_data rows W3,W2,W1,W0 -> mode=1 for exactly 4 consecutive cycles; weight_col equals W3..W0 on those cycles in order; then FEED.
- Preload with stall: w_valid low 2 cycles between beats 2 and 3 -> mode drops to 0 for exactly 2 cycles; total mode=1 cycles still 4.
- Skew: load_w=0, single vector {4,3,2,1} with act_last=1:
  - a_row row0=1 the cycle after acceptance.
  - row1=2 four cycles later, row2=3 eight cycles later, row3=4 twelve cycles later.
  - All other cycles zero.
  - done pulses 32 cycles after acceptance plus 1.
- Bubbles: vectors V0, gap, V1 -> row 0 shows V0, 0, V1 in consecutive cycles; act_ready=0 during DRAIN; start during busy ignored.
- Reset mid-FEED: rst_n low while skew chains hold data -> a_row, mode, busy = 0 immediately. After release, a clean job produces exactly the skew timing above.

Source files
------------

// File: rtl/sa_feeder_pkg.sv
// Shared definitions for the systolic-array feeder: FSM encoding and
// helpers that size the skew chains and job counters.
package sa_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_FEED   = 2'd2,
    ST_DRAIN  = 2'd3
  } feeder_state_e;

  function automatic int skew_depth(input int r, input int row_skew);
    return r * row_skew;
  endfunction

  function automatic int beat_cnt_w(input int rows);
    return $clog2(rows + 1);
  endfunction

  function automatic int drain_cnt_w(input int drain_cycles);
    return $clog2(drain_cycles + 1);
  endfunction

endpackage

// File: rtl/sa_feeder_if.sv
// Job control, weight/activation streams and array-boundary outputs of the feeder.
interface sa_feeder_if #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int PORT_WIDTH = 8
);
  logic                       start;
  logic                       load_w;
  logic                       busy;
  logic                       done;
  logic                       w_valid;
  logic                       w_ready;
  logic [COLS*PORT_WIDTH-1:0] w_data;
  logic                       act_valid;
  logic                       act_ready;
  logic [ROWS*PORT_WIDTH-1:0] act_data;
  logic                       act_last;
  logic                       mode;
  logic [COLS*PORT_WIDTH-1:0] weight_col;
  logic [ROWS*PORT_WIDTH-1:0] a_row;

  // master: layer controller / buffers; slave: the feeder itself
  modport master (
    output start, load_w, w_valid, w_data, act_valid, act_data, act_last,
    input  busy, done, w_ready, act_ready, mode, weight_col, a_row
  );

  modport slave (
    input  start, load_w, w_valid, w_data, act_valid, act_data, act_last,
    output busy, done, w_ready, act_ready, mode, weight_col, a_row
  );
endinterface

// File: rtl/sa_feeder_skew_line.sv
// Zero-reset shift register delaying one activation lane by DEPTH cycles;
// DEPTH=0 degenerates to a wire.
module sa_skew_line #(
  parameter int DEPTH      = 1,
  parameter int PORT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PORT_WIDTH-1:0] din,
  output logic [PORT_WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_chain
      logic [PORT_WIDTH-1:0] stage_q [DEPTH];
      logic [PORT_WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
          end
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sa_feeder.sv
// Drives one systolic PE array: weight preload (bottom row first, mode=1 per beat),
// then row-skewed activation streaming followed by a zero-fed drain.
module sa_feeder
  import sa_feeder_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int PORT_WIDTH   = 8,
  parameter int ROW_SKEW     = 4,
  parameter int DRAIN_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  sa_feeder_if.slave  bus
);

  localparam int BW = beat_cnt_w(ROWS);
  localparam int DW = drain_cnt_w(DRAIN_CYCLES);
  localparam int WW = COLS * PORT_WIDTH;
  localparam int AW = ROWS * PORT_WIDTH;

  feeder_state_e  state_q, state_d;
  logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [DW-1:0]  drain_cnt_q, drain_cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           w_ready_q, w_ready_d;
  logic           act_ready_q, act_ready_d;
  logic           mode_q, mode_d;
  logic [WW-1:0]  weight_col_q, weight_col_d;
  logic [AW-1:0]  a_row_q, a_row_d;

  logic           w_fire;
  logic           act_fire;
  logic [AW-1:0]  feed_vec;
  logic [AW-1:0]  skew_out;

  assign w_fire   = bus.w_valid & w_ready_q;
  assign act_fire = bus.act_valid & act_ready_q;
  // Bubbles, drain and idle cycles push zeros so the chains empty themselves.
  assign feed_vec = act_fire ? bus.act_data : '0;

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      sa_skew_line #(
        .DEPTH      (skew_depth(gi, ROW_SKEW)),
        .PORT_WIDTH (PORT_WIDTH)
      ) u_skew (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (feed_vec[gi*PORT_WIDTH +: PORT_WIDTH]),
        .dout  (skew_out[gi*PORT_WIDTH +: PORT_WIDTH])
      );
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    done_d       = 1'b0;
    mode_d       = 1'b0;
    weight_col_d = weight_col_q;
    a_row_d      = skew_out;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = bus.load_w ? ST_LOAD_W : ST_FEED;
          beat_cnt_d = '0;
        end
      end
      ST_LOAD_W: begin
        if (w_fire) begin
          weight_col_d = bus.w_data;
          mode_d       = 1'b1;
          beat_cnt_d   = beat_cnt_q + 1'b1;
          if (beat_cnt_q == BW'(ROWS - 1)) begin
            state_d = ST_FEED;
          end
        end
      end
      ST_FEED: begin
        if (act_fire && bus.act_last) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (drain_cnt_q == DW'(DRAIN_CYCLES - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Readies and busy follow the next state so their registered copies match state_q.
    busy_d      = (state_d != ST_IDLE);
    w_ready_d   = (state_d == ST_LOAD_W);
    act_ready_d = (state_d == ST_FEED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      beat_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      w_ready_q    <= 1'b0;
      act_ready_q  <= 1'b0;
      mode_q       <= 1'b0;
      weight_col_q <= '0;
      a_row_q      <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      w_ready_q    <= w_ready_d;
      act_ready_q  <= act_ready_d;
      mode_q       <= mode_d;
      weight_col_q <= weight_col_d;
      a_row_q      <= a_row_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.w_ready    = w_ready_q;
  assign bus.act_ready  = act_ready_q;
  assign bus.mode       = mode_q;
  assign bus.weight_col = weight_col_q;
  assign bus.a_row      = a_row_q;

endmodule

// File: tb/tb_sa_feeder.sv
// Self-checking bench for sa_feeder: per-job timeline model plus directed
// preload, stall, skew, bubble and mid-feed reset sequences.
module tb_sa_feeder;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int PW    = 8;
  localparam int SKEW  = 4;
  localparam int DRAIN = 32;
  localparam int WW    = COLS * PW;
  localparam int AW    = ROWS * PW;
  localparam int MAXT  = 128;
  localparam int TW    = 5 + WW + AW;

  logic clk;
  logic rst_n;

  sa_feeder_if #(.ROWS(ROWS), .COLS(COLS), .PORT_WIDTH(PW)) bus ();

  sa_feeder #(
    .ROWS(ROWS), .COLS(COLS), .PORT_WIDTH(PW),
    .ROW_SKEW(SKEW), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Job description consumed by run_job
  int            wgap[$];
  logic [WW-1:0] wdat[$];
  int            vgap[$];
  logic [AW-1:0] vdat[$];

  logic [WW-1:0] wcol_model = '0;
  int            last_modes;

  logic [AW-1:0] obs_arow [MAXT];
  logic          obs_done [MAXT];
  logic          obs_busy [MAXT];

  typedef struct {
    int            k;
    logic [AW-1:0] arow;
    logic          done;
    logic          busy;
  } skew_rec_t;

  function automatic logic [TW-1:0] actual_tuple();
    return {bus.busy, bus.done, bus.w_ready, bus.act_ready, bus.mode, bus.weight_col, bus.a_row};
  endfunction

  task automatic check(input string name, input logic [TW-1:0] got, input logic [TW-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.load_w    = 1'b0;
    bus.w_valid   = 1'b0;
    bus.w_data    = '0;
    bus.act_valid = 1'b0;
    bus.act_data  = '0;
    bus.act_last  = 1'b0;
  endtask

  // Expected behaviour is laid out as a timeline relative to the start cycle k=0:
  // beat accepted in cycle c -> mode/weight visible at c+1; vector accepted in c ->
  // row r visible at c+1+r*SKEW; done DRAIN+1 cycles after the last vector.
  task automatic run_job(input string name, input bit lw, input bit junk);
    int            beat_c[ROWS];
    int            vec_c[$];
    int            cur, f, L, E, D, T, nv, modes;
    logic [AW-1:0] e_arow [MAXT];
    logic          e_mode [MAXT];
    logic          wset   [MAXT];
    logic [WW-1:0] wval   [MAXT];
    logic          d_wv   [MAXT];
    logic          d_av   [MAXT];
    logic          d_al   [MAXT];
    logic [AW-1:0] d_ad   [MAXT];
    logic [WW-1:0] wcol;
    logic [TW-1:0] want;

    nv  = vdat.size();
    L   = 0;
    cur = 1;
    if (lw) begin
      for (int i = 0; i < ROWS; i++) begin
        cur += wgap[i];
        beat_c[i] = cur;
        cur++;
      end
      L = beat_c[ROWS-1];
      f = L + 1;
    end else begin
      f = 1;
    end
    cur = f;
    for (int j = 0; j < nv; j++) begin
      cur += vgap[j];
      vec_c.push_back(cur);
      cur++;
    end
    E = vec_c[nv-1];
    D = E + DRAIN + 1;
    T = D + 2;

    for (int k = 0; k < MAXT; k++) begin
      e_arow[k] = '0; e_mode[k] = 1'b0; wset[k] = 1'b0; wval[k] = '0;
      d_wv[k] = 1'b0; d_av[k] = 1'b0; d_al[k] = 1'b0; d_ad[k] = '0;
    end
    if (lw) begin
      for (int i = 0; i < ROWS; i++) begin
        e_mode[beat_c[i]+1] = 1'b1;
        wset[beat_c[i]+1]   = 1'b1;
        wval[beat_c[i]+1]   = wdat[i];
        d_wv[beat_c[i]]     = 1'b1;
      end
    end
    for (int j = 0; j < nv; j++) begin
      d_av[vec_c[j]] = 1'b1;
      d_ad[vec_c[j]] = vdat[j];
      d_al[vec_c[j]] = (j == nv - 1);
      for (int r = 0; r < ROWS; r++) begin
        e_arow[vec_c[j] + 1 + r*SKEW][r*PW +: PW] = vdat[j][r*PW +: PW];
      end
    end

    wcol  = wcol_model;
    modes = 0;
    for (int k = 0; k < T; k++) begin
      @(posedge clk);
      #1;
      bus.start  = (k == 0) || (junk && k >= 1 && k < D && $urandom_range(0, 7) == 0);
      bus.load_w = (k == 0) ? lw : 1'($urandom_range(0, 1));
      if (lw && k >= 1 && k <= L) begin
        bus.w_valid = d_wv[k];
        bus.w_data  = d_wv[k] ? wdat[0] : WW'($urandom);
        if (d_wv[k]) void'(wdat.pop_front());
      end else begin
        bus.w_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.w_data  = WW'($urandom);
      end
      if (k >= f && k <= E) begin
        bus.act_valid = d_av[k];
        bus.act_data  = d_av[k] ? d_ad[k] : AW'($urandom);
        bus.act_last  = d_av[k] ? d_al[k] : 1'($urandom_range(0, 1));
      end else begin
        bus.act_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.act_data  = AW'($urandom);
        bus.act_last  = 1'($urandom_range(0, 1));
      end

      @(negedge clk);
      if (wset[k]) wcol = wval[k];
      want = {(k >= 1 && k < D), (k == D), (lw && k >= 1 && k <= L),
              (k >= f && k <= E), e_mode[k], wcol, e_arow[k]};
      check($sformatf("%s cyc=%0d", name, k), actual_tuple(), want);
      obs_arow[k] = bus.a_row;
      obs_done[k] = bus.done;
      obs_busy[k] = bus.busy;
      if (bus.mode === 1'b1) modes++;
    end
    wcol_model = wcol;
    last_modes = modes;
    $display("job %s: load_w=%0d vecs=%0d cycles=%0d mode_cycles=%0d", name, lw, nv, T, modes);
  endtask

  task automatic clear_job();
    wgap.delete(); wdat.delete(); vgap.delete(); vdat.delete();
  endtask

  initial begin
    skew_rec_t tbl[11];
    int        nv;
    bit        lw;

    tbl[0]  = '{0,  32'h00000000, 1'b0, 1'b0};
    tbl[1]  = '{1,  32'h00000000, 1'b0, 1'b1};
    tbl[2]  = '{2,  32'h00000001, 1'b0, 1'b1};
    tbl[3]  = '{3,  32'h00000000, 1'b0, 1'b1};
    tbl[4]  = '{6,  32'h00000200, 1'b0, 1'b1};
    tbl[5]  = '{10, 32'h00030000, 1'b0, 1'b1};
    tbl[6]  = '{14, 32'h04000000, 1'b0, 1'b1};
    tbl[7]  = '{15, 32'h00000000, 1'b0, 1'b1};
    tbl[8]  = '{33, 32'h00000000, 1'b0, 1'b1};
    tbl[9]  = '{34, 32'h00000000, 1'b1, 1'b0};
    tbl[10] = '{35, 32'h00000000, 1'b0, 1'b0};

    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("reset_state", actual_tuple(), '0);
    rst_n = 1'b1;

    // Back-to-back preload, rows presented bottom first
    clear_job();
    wgap = '{0, 0, 0, 0};
    wdat = '{32'h33323130, 32'h2322F120, 32'h13127F10, 32'h83020100};
    vgap = '{0};
    vdat = '{32'h01020304};
    run_job("preload", 1'b1, 1'b0);
    total++;
    if (last_modes != ROWS) begin
      bad++;
      $display("FAIL preload_mode_count got=%0d want=%0d", last_modes, ROWS);
    end

    // Two stall cycles between the second and third beats
    clear_job();
    wgap = '{0, 0, 2, 0};
    wdat = '{32'hA3A2A1A0, 32'hB3B2B1B0, 32'hC3C2C1C0, 32'hD3D2D1D0};
    vgap = '{1, 0};
    vdat = '{32'h11223344, 32'h55667788};
    run_job("stall", 1'b1, 1'b0);
    total++;
    if (last_modes != ROWS) begin
      bad++;
      $display("FAIL stall_mode_count got=%0d want=%0d", last_modes, ROWS);
    end

    // V0, bubble, V1 with stray start/valid pulses while busy
    clear_job();
    vgap = '{0, 1};
    vdat = '{32'h0A0B0C0D, 32'hF1F2F3F4};
    run_job("bubble", 1'b0, 1'b1);

    for (int n = 0; n < 20; n++) begin
      clear_job();
      lw = 1'($urandom_range(0, 1));
      for (int i = 0; i < ROWS; i++) begin
        wgap.push_back(int'($urandom_range(0, 2)));
        wdat.push_back(WW'($urandom));
      end
      nv = int'($urandom_range(1, 8));
      for (int j = 0; j < nv; j++) begin
        vgap.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
        vdat.push_back(AW'($urandom));
      end
      run_job($sformatf("rand%0d", n), lw, 1'b1);
    end

    // Reset asserted mid-feed while the skew chains hold data
    @(posedge clk); #1;
    bus.start = 1'b1; bus.load_w = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.act_valid = 1'b1; bus.act_last = 1'b0;
    bus.act_data = AW'($urandom) | 32'h01010101;
    repeat (6) begin
      @(posedge clk); #1;
      bus.act_data = AW'($urandom) | 32'h01010101;
    end
    #1;
    check("busy_before_reset", {{(TW-1){1'b0}}, bus.busy}, {{(TW-1){1'b0}}, 1'b1});
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_mid_feed", actual_tuple(), '0);
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wcol_model = '0;

    // Single vector {4,3,2,1} after the reset: exact skew timing
    clear_job();
    vgap = '{0};
    vdat = '{32'h04030201};
    run_job("skew", 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      total++;
      if ({obs_arow[tbl[i].k], obs_done[tbl[i].k], obs_busy[tbl[i].k]} !==
          {tbl[i].arow, tbl[i].done, tbl[i].busy}) begin
        bad++;
        $display("FAIL skew_tbl k=%0d got a_row=%h done=%b busy=%b want a_row=%h done=%b busy=%b",
                 tbl[i].k, obs_arow[tbl[i].k], obs_done[tbl[i].k], obs_busy[tbl[i].k],
                 tbl[i].arow, tbl[i].done, tbl[i].busy);
      end
    end

    idle_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
